// File: rtl/i2s_tx.sv
// Philips I2S serializer: 16-bit L/R, MSB first, one-bit delay, bclk/lrclk from clk divider.
// Latency: samples taken at the n=16 strobe are loaded at the next n=1 fall and appear on sdata from there.
// No backpressure: the DAC is free-running; stop requests wait for a frame boundary.
module i2s_tx #(
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] left_sample,
  input  logic [15:0] right_sample,
  output logic        sample_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        busy
);

  localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(BCLK_HALF_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    n_q, n_d, n_nxt;
  logic [31:0]   sh_q, sh_d;
  logic          bclk_q, bclk_d;
  logic          lr_q, lr_d;
  logic          sd_q, sd_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      n_q     <= 5'd31;
      sh_q    <= '0;
      bclk_q  <= 1'b0;
      lr_q    <= 1'b0;
      sd_q    <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      bclk_q  <= bclk_d;
      lr_q    <= lr_d;
      sd_q    <= sd_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    n_d     = n_q;
    sh_d    = sh_q;
    bclk_d  = bclk_q;
    lr_d    = lr_q;
    sd_d    = sd_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    n_nxt   = n_q + 5'd1;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        n_d    = 5'd31;
        bclk_d = 1'b0;
        lr_d   = 1'b0;
        sd_d   = 1'b0;
        busy_d = 1'b0;
        if (enable) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_TC) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            // Falling edge: enable only matters on the step into n=1
            if (n_nxt == 5'd1 && !enable) begin
              state_d = IDLE;
              bclk_d  = 1'b0;
              lr_d    = 1'b0;
              sd_d    = 1'b0;
              n_d     = 5'd31;
              busy_d  = 1'b0;
              sh_d    = '0;
            end else begin
              n_d   = n_nxt;
              lr_d  = n_nxt[4];
              stb_d = (n_nxt == 5'd16);
              if (n_nxt == 5'd1) begin
                sh_d = {left_sample, right_sample};
                sd_d = left_sample[15];
              end else begin
                sh_d = {sh_q[30:0], 1'b0};
                sd_d = sh_q[30];
              end
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample_strobe = stb_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lr_q;
  assign i2s_sdata     = sd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (half-divider 4 and 1), a per-cycle timing/arithmetic
// reference model, a table of expected frame bits for a fixed sample pair, and directed corner cases.
module tb_i2s_tx;

  typedef struct {
    bit          run;
    int          t;
    logic [31:0] word;
    logic [4:0]  o;     // {busy, strobe, bclk, lrclk, sdata}
  } mdl_t;

  typedef struct {
    logic lr;
    logic sd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        en  [2];
  logic [15:0] lft [2];
  logic [15:0] rgt [2];
  logic        stb [2];
  logic        bck [2];
  logic        lrc [2];
  logic        sdt [2];
  logic        bsy [2];

  int  passed = 0;
  int  total  = 0;
  int  ncur   = 31;
  bit  started = 1'b0;
  mdl_t m0 = '{1'b0, 0, 32'h0, 5'h0};
  mdl_t m1 = '{1'b0, 0, 32'h0, 5'h0};
  vec_t tbl [32];

  always #5 clk = ~clk;

  i2s_tx #(.BCLK_HALF_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .enable(en[0]),
    .left_sample(lft[0]), .right_sample(rgt[0]),
    .sample_strobe(stb[0]), .i2s_bclk(bck[0]), .i2s_lrclk(lrc[0]),
    .i2s_sdata(sdt[0]), .busy(bsy[0])
  );

  i2s_tx #(.BCLK_HALF_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .enable(en[1]),
    .left_sample(lft[1]), .right_sample(rgt[1]),
    .sample_strobe(stb[1]), .i2s_bclk(bck[1]), .i2s_lrclk(lrc[1]),
    .i2s_sdata(sdt[1]), .busy(bsy[1])
  );

  function automatic int hdiv(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [4:0] get_o(input int d);
    return {bsy[d], stb[d], bck[d], lrc[d], sdt[d]};
  endfunction

  // Reference: time since RUN entry decides toggles; fall f carries bit n=(f-1)%32,
  // and the bit shown is a direct index into the most recently loaded 32-bit word.
  function automatic mdl_t step(input mdl_t m, input int h, input logic e, input logic [31:0] lr);
    mdl_t r;
    int k, n;
    r = m;
    r.o[3] = 1'b0;
    if (!m.run) begin
      if (e) begin
        r.run = 1'b1; r.t = 0; r.word = '0; r.o = 5'b10000;
      end
    end else begin
      r.t = m.t + 1;
      if (r.t % h == 0) begin
        k = r.t / h;
        if (k % 2 == 1) begin
          r.o[2] = 1'b1;
        end else begin
          n = (k / 2 - 1) % 32;
          if (n == 1 && !e) begin
            r.run = 1'b0; r.o = '0; r.word = '0;
          end else begin
            r.o[2] = 1'b0;
            r.o[1] = (n >= 16);
            r.o[3] = (n == 16);
            if (n == 1) r.word = lr;
            r.o[0] = (n == 0) ? r.word[0] : r.word[32 - n];
          end
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_a)
    if (!rst_a) m0 = '{1'b0, 0, 32'h0, 5'h0};
    else        m0 = step(m0, 4, en[0], {lft[0], rgt[0]});

  always @(posedge clk or negedge rst_b)
    if (!rst_b) m1 = '{1'b0, 0, 32'h0, 5'h0};
    else        m1 = step(m1, 1, en[1], {lft[1], rgt[1]});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cycle_model_div4", {27'd0, get_o(0)}, {27'd0, m0.o});
      chk("cycle_model_div1", {27'd0, get_o(1)}, {27'd0, m1.o});
    end
  end

  task automatic fall(input int d);
    repeat (2 * hdiv(d)) @(posedge clk);
    #2;
  endtask

  task automatic fall_to(input int d, input int tgt);
    do begin
      fall(d);
      ncur = (ncur + 1) % 32;
    end while (ncur != tgt);
  endtask

  // Scenarios: entry timing, silent frame 0, fixed-pattern frame 1, then random samples.
  task automatic run_seq(input int d);
    int h, n;
    h = hdiv(d);
    @(posedge clk); #2;
    lft[d] = '0; rgt[d] = '0; en[d] = 1'b1;
    @(posedge clk); #2;
    chk("run_entry", {27'd0, get_o(d)}, 32'b10000);
    for (int c = 1; c <= 2 * h; c++) begin
      @(posedge clk); #2;
      chk("bclk_phase", bck[d], (c >= h && c < 2 * h));
    end
    for (int f = 1; f <= 160; f++) begin
      if (f > 1) fall(d);
      n = (f - 1) % 32;
      chk("fall_lrclk", lrc[d], (n >= 16));
      chk("fall_strobe", stb[d], (n == 16));
      if (f <= 33) chk("frame0_sdata_zero", sdt[d], 1'b0);
      else if (f <= 65) begin
        chk("tbl_sdata", sdt[d], tbl[n].sd);
        chk("tbl_lrclk", lrc[d], tbl[n].lr);
      end
      if (n == 16) begin
        if (f == 17) begin
          lft[d] = 16'hA5C3; rgt[d] = 16'h0F81;
        end else begin
          lft[d] = 16'($urandom); rgt[d] = 16'($urandom);
        end
      end
    end
    ncur = 31;
  endtask

  initial begin
    logic [15:0] lbits;
    logic [14:0] rbits;
    int cnt;
    lbits = 16'b1010010111000011;
    rbits = 15'b000011111000000;
    for (int i = 1; i <= 16; i++) tbl[i] = '{1'b0, lbits[16 - i]};
    for (int i = 17; i <= 31; i++) tbl[i] = '{1'b1, rbits[31 - i]};
    tbl[16].lr = 1'b1;
    tbl[0] = '{1'b0, 1'b1};

    rst_a = 1'b0; rst_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; lft[d] = '0; rgt[d] = '0;
    end
    @(posedge clk); #2;
    chk("reset_div4", {27'd0, get_o(0)}, 32'd0);
    chk("reset_div1", {27'd0, get_o(1)}, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_hold", {27'd0, get_o(0)}, 32'd0);

    run_seq(0);

    // Enable glitch inside a frame is ignored; a low enable at the 0->1 step stops.
    fall_to(0, 5);  en[0] = 1'b0;
    fall_to(0, 20); en[0] = 1'b1;
    fall_to(0, 1);  chk("no_stop_busy", bsy[0], 1'b1);
    fall_to(0, 30); en[0] = 1'b0;
    fall_to(0, 0);  chk("last_bit_busy", bsy[0], 1'b1);
    fall(0);
    chk("stop_idle", {27'd0, get_o(0)}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (stb[0]) cnt++;
    end
    chk("no_strobe_idle", cnt, 0);
    chk("idle_after_stop", {27'd0, get_o(0)}, 32'd0);

    // Async reset mid-frame, then restart with enable still high.
    lft[0] = '0; rgt[0] = '0; en[0] = 1'b1;
    @(posedge clk); #2;
    chk("reenable_entry", {27'd0, get_o(0)}, 32'b10000);
    ncur = 31;
    fall_to(0, 9);
    rst_a = 1'b0;
    #1;
    chk("rst_async_zero", {27'd0, get_o(0)}, 32'd0);
    @(posedge clk); #2;
    rst_a = 1'b1;
    @(posedge clk); #2;
    chk("rst_reentry", {27'd0, get_o(0)}, 32'b10000);
    ncur = 31;
    for (int i = 0; i < 32; i++) begin
      fall_to(0, (ncur + 1) % 32);
      chk("rst_frame0_sdata", sdt[0], 1'b0);
      chk("rst_frame0_lrclk", lrc[0], (ncur >= 16));
    end

    run_seq(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
